// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
// Statistics widths apply only when the design is built with TICK_SCHED_STATS_EN.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ID_W   = $clog2(DEF_NUM_CH);
  localparam int STATS_W    = 16;
  localparam int TO_STATS_W = 8;

endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// Round-robin arbiter: combinational search from the pointer, and a pointer that
// advances past the winner only when the grant is taken.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              grant_stb,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_idx,
  output logic [ID_W-1:0]   pointer
);

  logic [ID_W-1:0] ptr_r;
  logic            valid_s;
  logic [ID_W-1:0] idx_s;

  // Walk downward so the requester closest to the pointer is the last to write.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    valid_s  = 1'b0;
    idx_s    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand     = int'(ptr_r) + i;
      cand     = (cand >= NUM_CH) ? (cand - NUM_CH) : cand;
      cand_idx = ID_W'(cand);
      valid_s  = valid_s | req[cand_idx];
      idx_s    = req[cand_idx] ? cand_idx : idx_s;
    end
  end

  // Pointer register, moved to the channel after the winner on a taken grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (grant_stb && valid_s) begin
      ptr_r <= (idx_s == ID_W'(NUM_CH - 1)) ? '0 : (idx_s + ID_W'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant_valid = valid_s;
  assign grant_idx   = idx_s;
  assign pointer     = ptr_r;

endmodule

// File: rtl/tick_sched.sv
// Shares rate-generator ticks among NUM_CH channels: one start per tick, then wait
// for done or timeout. Define TICK_SCHED_STATS_EN to add missed_cnt/to_cnt counters.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      rate_in,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         start,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      busy,
  output logic                      overrun,
`ifdef TICK_SCHED_STATS_EN
  output logic [STATS_W-1:0]        missed_cnt,
  output logic [TO_STATS_W-1:0]     to_cnt,
`endif
  output logic                      timeout
);

  localparam int ID_W = $clog2(NUM_CH);

  state_t            state_r, next_s;
  logic              rate_q_r;
  logic              tick_s;
  logic [TO_W-1:0]   wait_cnt_r;
  logic              grant_stb_s, ovr_evt_s, to_evt_s;
  logic              gnt_valid_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [ID_W-1:0]   ptr_s;
  logic [NUM_CH-1:0] start_r;
  logic [ID_W-1:0]   grant_id_r;
  logic              busy_r, overrun_r, timeout_r;

  assign tick_s = rate_in ^ rate_q_r;

  rr_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_stb   (grant_stb_s),
    .grant_valid (gnt_valid_s),
    .grant_idx   (gnt_idx_s),
    .pointer     (ptr_s)
  );

  // Next-state and event decode; done beats an expiring wait counter.
  always_comb begin
    next_s      = state_r;
    grant_stb_s = 1'b0;
    ovr_evt_s   = 1'b0;
    to_evt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s && en && gnt_valid_s) begin
          next_s      = START;
          grant_stb_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      START: begin
        next_s    = ACTIVE;
        ovr_evt_s = tick_s;
      end
      ACTIVE: begin
        ovr_evt_s = tick_s;
        if (done[grant_id_r]) begin
          next_s = IDLE;
        end else if (wait_cnt_r == TO_W'(TIMEOUT - 1)) begin
          next_s   = IDLE;
          to_evt_s = 1'b1;
        end else begin
          next_s = ACTIVE;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, edge-detect history, wait counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rate_q_r   <= 1'b0;
      wait_cnt_r <= '0;
      start_r    <= '0;
      grant_id_r <= '0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= next_s;
      rate_q_r   <= rate_in;
      wait_cnt_r <= (state_r == ACTIVE) ? (wait_cnt_r + TO_W'(1)) : '0;
      start_r    <= grant_stb_s ? (NUM_CH'(1) << gnt_idx_s) : '0;
      grant_id_r <= grant_stb_s ? gnt_idx_s : grant_id_r;
      busy_r     <= (next_s != IDLE);
      overrun_r  <= ovr_evt_s;
      timeout_r  <= to_evt_s;
    end
  end

`ifdef TICK_SCHED_STATS_EN
  logic [STATS_W-1:0]    missed_r;
  logic [TO_STATS_W-1:0] to_evt_cnt_r;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      missed_r     <= '0;
      to_evt_cnt_r <= '0;
    end else begin
      missed_r     <= (ovr_evt_s && (missed_r != '1)) ? (missed_r + STATS_W'(1)) : missed_r;
      to_evt_cnt_r <= (to_evt_s && (to_evt_cnt_r != '1)) ? (to_evt_cnt_r + TO_STATS_W'(1)) : to_evt_cnt_r;
    end
  end

  assign missed_cnt = missed_r;
  assign to_cnt     = to_evt_cnt_r;
`endif

  assign start    = start_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;
  assign timeout  = timeout_r;

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Round-robin scheduler that shares the periodic tick from the rate generator among NUM_CH consumer blocks.
- Converts the generator's toggling output (each edge = one period) into single-cycle ticks.
- On each tick, grants one requesting channel a start pulse, then waits for that channel's done, with a timeout.
- Sits between the rate generator and the per-channel datapath engines.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- TIMEOUT, 1024, max clk cycles in ACTIVE waiting for done before forced release
- TO_W, 11, width of timeout counter (must hold TIMEOUT)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scheduler enable; 0 = ignore ticks, finish current grant only
- rate_in  in  1  toggling output of rate generator; every edge is one tick
- req  in  NUM_CH  per-channel request level, held until granted
- done  in  NUM_CH  per-channel single-cycle completion pulse
- start  out  NUM_CH  one-hot single-cycle start pulse to granted channel
- grant_id  out  clog2(NUM_CH)  index of current/last granted channel
- busy  out  1  high while in START or ACTIVE
- overrun  out  1  single-cycle pulse: tick arrived while busy (tick dropped)
- timeout  out  1  single-cycle pulse: ACTIVE ended by TIMEOUT, not done

Behaviour:
- Reset values: start=0, grant_id=0, busy=0, overrun=0, timeout=0, FSM=IDLE, rr pointer=0, rate_in_q=0, timeout counter=0.
- Tick detect: rate_in_q <= rate_in each clk; tick = rate_in ^ rate_in_q (combinational, same cycle as edge). The first edge after reset is a tick.
- FSM states:
  - IDLE: tick & en & |req -> START; arbitration latched this cycle. Tick with no req or en=0: no action, no overrun.
  - START (1 cycle): start[grant_id]=1, busy=1 -> ACTIVE; timeout counter cleared.
  - ACTIVE: busy=1. done[grant_id] -> IDLE. Counter reaches TIMEOUT-1 without done -> IDLE with timeout=1 for one cycle. done on other channels is ignored.
- Latency: tick edge on rate_in at cycle N -> start pulse at cycle N+1.
- Arbitration: round-robin. Search starts at pointer, which points to the channel after the last grant. The pointer updates only on grant. Example: req=4'b1111, pointer=0 -> grants 0,1,2,3,0...
- overrun: a tick in START or ACTIVE pulses overrun and is discarded, not queued.
- Simultaneous done and tick in ACTIVE: the FSM returns to IDLE and overrun pulses. The tick is not re-used.
- Simultaneous done and timeout-expiry cycle: done wins, no timeout pulse.
- req deasserted after grant: no effect on the current grant.
- en falling in START/ACTIVE: the grant completes normally.
- rst mid-operation: everything returns to reset values immediately (async); a pending start is suppressed.
- grant_id holds its value in IDLE.

Optional Feature:
- Macro TICK_SCHED_STATS_EN.
- Defined: adds output missed_cnt [15:0], which counts overrun events. It saturates at 16'hFFFF and clears on rst.
- Also adds output to_cnt [7:0], a saturating timeout-event count.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package tick_sched_pkg holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, ACTIVE=2'd2
  - localparam for ID width
  - STATS_W=16
- Sub-module rr_arbiter (NUM_CH parameter) contains:
  - inputs: req, pointer
  - outputs: grant valid, grant index (combinational)
  - pointer register update on a grant strobe

Test Plan:
- Basic grant: req=4'b0100, toggle rate_in at cycle 10 -> start=4'b0100 at cycle 11, grant_id=2, busy 11..done; done[2] at cycle 15 -> busy=0 at 16.
- Round-robin: req=4'b1111 constant, done 3 cycles after each start, 5 ticks -> grant_id sequence 0,1,2,3,0; no overrun.
- Overrun: grant ch0, withhold done, toggle rate_in twice -> two overrun pulses, no second start. With TICK_SCHED_STATS_EN, missed_cnt=2.
- Timeout: TIMEOUT=16, grant ch1, never assert done -> timeout pulse 16 cycles after entering ACTIVE, FSM IDLE, next tick grants ch2 if requested.
- Tie cases: done[0] coincident with tick -> IDLE plus overrun. done on the expiry cycle -> no timeout. done[3] while ch0 granted -> ignored.
- Reset/enable: assert rst during ACTIVE -> busy=0, start=0 asynchronously, pointer=0. en=0 with req=4'b0001 and 3 ticks -> no start, no overrun.
